// File: rtl/instr_fetch_unit_pkg.sv
// Shared pipeline constants and the fetch bundle type used between fetch and decode.
package instr_fetch_unit_pkg;

  localparam int          PC_W         = 32;
  localparam int          INSTR_W      = 32;
  localparam int          PC_INC       = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry hold register for a stalled word, plus the mux that selects it over the live ROM response.
module fetch_hold_buffer
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               capture,
  input  logic               clear,
  input  logic [INSTR_W-1:0] resp_instr,
  input  logic [ADDR_W-1:0]  resp_pc,
  input  logic               resp_valid,
  output logic               hold_valid,
  output logic [INSTR_W-1:0] hold_instr,
  output logic [ADDR_W-1:0]  hold_pc,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid_out
);

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else if (clear) begin
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_valid <= 1'b1;
      hold_instr <= instruction;
      hold_pc    <= pc_out;
    end
  end

  // A held word always takes precedence over the live response.
  always_comb begin
    instruction = resp_instr;
    pc_out      = resp_pc;
    if (hold_valid) begin
      instruction = hold_instr;
      pc_out      = hold_pc;
    end
    valid_out = hold_valid | resp_valid;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, drives the synchronous ROM and presents PC-tagged words to decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               valid_out
);

  localparam logic [ADDR_W-1:0] INC      = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_MK = ~ADDR_W'(3);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  resp_pc;
  logic               resp_valid;
  logic               hold_valid;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pc;
  logic               capture;
  logic               clear;
  logic [ADDR_W-1:0]  target_aligned;

  assign target_aligned = branch_target & ALIGN_MK;

  // A redirect or a consuming edge empties the hold; a stall parks the displayed word once.
  always_comb begin
    clear   = branch_taken | ~stall;
    capture = ~branch_taken & stall & valid_out & ~hold_valid;
  end

  // Address stage: fetch_pc is sampled by the ROM; response stage tags the returning word.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= '0;
      resp_valid <= 1'b0;
    end else if (branch_taken) begin
      fetch_pc   <= target_aligned;
      resp_valid <= 1'b0;
    end else if (stall) begin
      resp_valid <= 1'b0;
    end else begin
      resp_pc    <= fetch_pc;
      resp_valid <= 1'b1;
      fetch_pc   <= fetch_pc + INC;
    end
  end

  fetch_hold_buffer #(
    .ADDR_W(ADDR_W)
  ) u_hold (
    .clock       (clock),
    .reset       (reset),
    .capture     (capture),
    .clear       (clear),
    .resp_instr  (rom_instruction),
    .resp_pc     (resp_pc),
    .resp_valid  (resp_valid),
    .hold_valid  (hold_valid),
    .hold_instr  (hold_instr),
    .hold_pc     (hold_pc),
    .instruction (instruction),
    .pc_out      (pc_out),
    .valid_out   (valid_out)
  );

  assign rom_address = fetch_pc;
  assign pc_plus4    = pc_out + INC;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then randomized stall/branch/reset traffic against a word-stream model.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] rom_address;
  logic [31:0] rom_instruction;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  // Model: what decode sees, and which PC the next sequential word will carry.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;
  logic        m_fresh_reset;

  always #5 clock = ~clock;

  instr_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .rom_address    (rom_address),
    .rom_instruction(rom_instruction),
    .instruction    (instruction),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .valid_out      (valid_out)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    if (a < 32'd16) begin
      case (a[3:2])
        2'd0:    w = 32'h80010C0A;
        2'd1:    w = 32'h04011000;
        2'd2:    w = 32'h0C011800;
        default: w = 32'h14432000;
      endcase
    end else if (a == 32'hFFFF_FFFC) begin
      w = 32'hDEADBEEF;
    end else begin
      w = (a * 32'h9E3779B1) ^ 32'h1234_5678;
    end
    return w;
  endfunction

  // One-cycle registered ROM.
  always @(posedge clock) rom_instruction <= rom_word(rom_address);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("rom_address", rom_address, m_next);
    check_eq("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
    if (m_valid) begin
      check_eq("pc_out", pc_out, m_pc);
      check_eq("instruction", instruction, rom_word(m_pc));
      check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    end
    if (m_fresh_reset) check_eq("pc_out_reset", pc_out, 32'd0);
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
    reset = r;
    stall = s;
    branch_taken = b;
    branch_target = t;
    @(posedge clock);
    if (r) begin
      m_valid = 1'b0;
      m_pc = 32'd0;
      m_next = 32'd0;
      m_fresh_reset = 1'b1;
    end else if (b) begin
      m_valid = 1'b0;
      m_next = {t[31:2], 2'b00};
      m_fresh_reset = 1'b0;
    end else if (!s) begin
      m_valid = 1'b1;
      m_pc = m_next;
      m_next = m_next + 32'd4;
      m_fresh_reset = 1'b0;
    end
    @(negedge clock);
    check_all();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] tgt;
    int sel;

    m_valid = 1'b0; m_pc = '0; m_next = '0; m_fresh_reset = 1'b1;

    // Reset then free-run.
    do_reset();
    check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_romaddr", rom_address, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check_eq("fr_pc", pc_out, 32'(i * 4));
      check_eq("fr_lead", rom_address, pc_out + 32'd4);
    end

    // Stall three cycles while pc_out=4, then release without a gap.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check_eq("stall_instr", instruction, 32'h04011000);
      check_eq("stall_pc", pc_out, 32'd4);
    end
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("release_pc", pc_out, 32'd8);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("release_pc2", pc_out, 32'd12);

    // Redirect during a stall, unaligned target.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_000E);
    check_eq("br_bubble", {31'd0, valid_out}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("br_pc", pc_out, 32'd12);
    check_eq("br_instr", instruction, 32'h14432000);

    // Redirect to the top word and wrap.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("wrap_instr", instruction, 32'hDEADBEEF);
    check_eq("wrap_plus4", pc_plus4, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("wrap_pc", pc_out, 32'd0);
    check_eq("wrap_next", instruction, 32'h80010C0A);

    // Reset while a word is held.
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    check_eq("hrst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("hrst_addr", rom_address, 32'd0);

    // Stall during the post-reset bubble.
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("bub_valid", {31'd0, valid_out}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("bub_pc", pc_out, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       tgt = 32'($urandom_range(0, 15));
        1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        2:       tgt = $urandom;
        default: tgt = 32'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 10),
           tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Requester side of the synchronous byte-addressed instruction ROM: owns the PC, drives the ROM address, and pairs each returned word with its PC.
- Hands words to decode through a valid/stall handshake, with a one-entry hold buffer so a stall never loses a word.
- Takes branch redirects from execute.
- Sits between the ROM and the decode stage of the single-cycle-issue datapath.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, PC and ROM address width.

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-high.
- stall  input  1  decode cannot accept this cycle; the displayed word is not consumed.
- branch_taken  input  1  redirect request from execute.
- branch_target  input  ADDR_W  redirect address; bits [1:0] are forced to 0.
- rom_address  output  ADDR_W  byte address to ROM; a register output with no combinational input path.
- rom_instruction  input  32  ROM data, valid the cycle after the address is sampled, {byte a, a+1, a+2, a+3}.
- instruction  output  32  word presented to decode.
- pc_out  output  ADDR_W  byte address of `instruction`.
- pc_plus4  output  ADDR_W  pc_out + 4, mod 2^ADDR_W.
- valid_out  output  1  `instruction` and `pc_out` are a live fetch.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous, active-high, port `reset`.
- Registers: fetch_pc (drives rom_address), resp_pc, resp_valid, hold_valid, hold_instr, hold_pc.
- Output mux:
  - hold_valid=1: outputs come from hold_instr/hold_pc.
  - otherwise: instruction=rom_instruction, pc_out=resp_pc.
  - valid_out = hold_valid | resp_valid.
- A word is consumed at a rising edge where valid_out=1 and stall=0.
- Reset values: fetch_pc=RESET_PC, resp_valid=0, hold_valid=0, hold_instr=0, hold_pc=0, resp_pc=0. Consequently rom_address=RESET_PC, valid_out=0, instruction=rom_instruction (don't-care), pc_out=0.
- Reset mid-operation (including during a stall or redirect) discards all in-flight and held words.
- Reset latency: the word at RESET_PC has valid_out=1 in the 2nd cycle after reset deasserts (one bubble).
- Per-edge priority: reset > branch_taken > stall > run.
  - RUN (stall=0, no branch): resp_pc<=fetch_pc; resp_valid<=1; fetch_pc<=fetch_pc+4; hold_valid<=0.
    - Steady-state throughput is one word per cycle.
    - After a stall releases there is no bubble: the cycle after release shows the next sequential word.
  - STALL (stall=1, no branch):
    - fetch_pc is held.
    - resp_valid<=0; the word the ROM returns next cycle is discarded and refetched later.
    - If valid_out=1 and hold_valid=0: hold_instr<=instruction, hold_pc<=pc_out, hold_valid<=1.
    - If hold_valid=1: the hold is kept unchanged.
    - If valid_out=0 (bubble): nothing is captured; the unit stays empty.
    - Outputs stay stable for the whole stall.
  - REDIRECT (branch_taken=1, stall ignored): fetch_pc<={branch_target[31:2],2'b00}; resp_valid<=0; hold_valid<=0.
    - The displayed word is dropped.
    - Exactly one bubble: target word valid_out=1 two cycles after the redirect cycle.
    - Back-to-back redirects: the last one wins; each resets the two-cycle latency.
- Implicit states: EMPTY (valid_out=0), STREAM (resp_valid), HELD (hold_valid). No encoded FSM is required, but the three-state view is normative for verification.
- Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag raised. pc_plus4 wraps the same way.
- Misalignment: fetch_pc[1:0] is always 00.

Decomposition:
- Shared package, alongside the other pipeline constants: RESET_PC default, instruction width 32, PC increment constant 4, and a fetch-bundle typedef {instruction, pc, valid}.
- One natural sub-module, fetch_hold_buffer: the one-entry hold register plus output mux. It has inputs capture/clear and exposes the hold valid/instruction/pc. Everything else stays in instr_fetch_unit.

Test Plan:
- Bench ROM model is big-endian and one-cycle registered; ROM at 0..15 holds 32'h80010C0A, 32'h04011000, 32'h0C011800, 32'h14432000.
- Reset then free-run -> valid_out=0 in cycle 1; cycles 2..5 show pc_out 0,4,8,12 with matching words; pc_plus4=pc_out+4; rom_address leads pc_out by 4.
- Stall for 3 cycles while pc_out=4 -> instruction=32'h04011000, pc_out=4, valid_out=1 throughout; release -> next cycle pc_out=8, then 12, no gap.
- branch_taken with target 32'h0000000E (low bits forced to 0) during stall while pc_out=4 -> next cycle valid_out=0; following cycle pc_out=12, instruction=32'h14432000.
- Redirect to 32'hFFFFFFFC with ROM returning 32'hDEADBEEF -> shows pc_out=FFFFFFFC, pc_plus4=0; next word pc_out=0, instruction=32'h80010C0A.
- Reset asserted in a HELD cycle -> next cycle valid_out=0, rom_address=RESET_PC; held word never reappears.
- Stall asserted during the post-reset bubble -> valid_out stays 0; first valid word pc_out=0 appears one cycle after stall drops.
